// File: rtl/aud_transport_ctrl.sv
// Record/play transport controller: codec-init sequencing, slot-partitioned SRAM addressing, per-slot lengths.
// Build option: define AUD_LOOP_PLAY_EN to loop playback at the recorded end instead of returning to IDLE.
module aud_transport_ctrl #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned SLOT_N      = 4,
    parameter int unsigned SAMPLE_RATE = 32000,
    parameter int unsigned TIME_W      = 6,
    localparam int unsigned SLOT_W     = (SLOT_N > 1) ? $clog2(SLOT_N) : 1
) (
    input  logic              i_AUD_BCLK,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic [SLOT_W-1:0] i_slot,
    input  logic              i_i2c_done,
    input  logic              i_lrck,
    output logic [2:0]        o_state,
    output logic              o_i2c_start,
    output logic              o_rec_en,
    output logic              o_play_en,
    output logic              o_stop,
    output logic [ADDR_W-1:0] o_addr,
    output logic [TIME_W-1:0] o_rec_time,
    output logic [TIME_W-1:0] o_play_time,
    output logic              o_full
);
    localparam int unsigned LOG_N = $clog2(SLOT_N);
    localparam int unsigned OFF_W = ADDR_W - LOG_N;
    localparam int unsigned LEN_W = OFF_W + 1;
    localparam int unsigned LEN_N = 1 << SLOT_W;
    localparam int unsigned SUB_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SAMPLE_RATE - 1);
    localparam logic [LEN_W-1:0] REG_LEN = LEN_W'(1) << OFF_W;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_RECD   = 3'd2;
    localparam logic [2:0] S_RPAUSE = 3'd3;
    localparam logic [2:0] S_PLAY   = 3'd4;
    localparam logic [2:0] S_PPAUSE = 3'd5;

    logic [2:0]        state, state_n;
    logic [SLOT_W-1:0] slot_q, slot_n;
    logic [OFF_W-1:0]  off, off_n;
    logic [LEN_W-1:0]  len [LEN_N];
    logic [TIME_W-1:0] rec_n, play_n;
    logic [SUB_W-1:0]  sub, sub_n;
    logic              full_n, stop_n;
    logic              lrck_d, lrck_rise;
    logic              len_wr;
    logic [LEN_W-1:0]  len_wd;
    logic              tick_rec, tick_play;
    logic [ADDR_W-1:0] addr_n;

    assign lrck_rise = i_lrck & ~lrck_d;

    // Auto-stop is evaluated before keys so a coincident key is dropped.
    always_comb begin
        state_n   = state;
        slot_n    = slot_q;
        off_n     = off;
        rec_n     = o_rec_time;
        play_n    = o_play_time;
        sub_n     = sub;
        full_n    = o_full;
        len_wr    = 1'b0;
        len_wd    = '0;
        tick_rec  = 1'b0;
        tick_play = 1'b0;
        case (state)
            S_INIT: if (i_i2c_done) state_n = S_IDLE;
            S_IDLE: begin
                if (i_key_stop) begin
                    state_n = S_IDLE;
                end else if (i_key_rec) begin
                    state_n = S_RECD;
                    slot_n  = i_slot;
                    off_n   = '0;
                    rec_n   = '0;
                    sub_n   = '0;
                    full_n  = 1'b0;
                end else if (i_key_play && len[i_slot] != '0) begin
                    state_n = S_PLAY;
                    slot_n  = i_slot;
                    off_n   = '0;
                    play_n  = '0;
                    sub_n   = '0;
                end
            end
            S_RECD, S_RPAUSE: begin
                if (state == S_RECD && lrck_rise && off == '1) begin
                    len_wr   = 1'b1;
                    len_wd   = REG_LEN;
                    full_n   = 1'b1;
                    state_n  = S_IDLE;
                    tick_rec = 1'b1;
                end else if (i_key_stop) begin
                    len_wr  = 1'b1;
                    len_wd  = LEN_W'(off);
                    state_n = S_IDLE;
                end else if (i_key_rec) begin
                    state_n = (state == S_RECD) ? S_RPAUSE : S_RECD;
                end else if (i_key_play) begin
                    len_wr  = 1'b1;
                    len_wd  = LEN_W'(off);
                    state_n = S_PLAY;
                    off_n   = '0;
                    play_n  = '0;
                    sub_n   = '0;
                end else if (state == S_RECD && lrck_rise) begin
                    off_n    = off + 1'b1;
                    tick_rec = 1'b1;
                end
            end
            S_PLAY, S_PPAUSE: begin
                if (state == S_PLAY && lrck_rise && (LEN_W'(off) + LEN_W'(1)) == len[slot_q]) begin
`ifdef AUD_LOOP_PLAY_EN
                    off_n   = '0;
                    play_n  = '0;
                    sub_n   = '0;
`else
                    state_n = S_IDLE;
`endif
                end else if (i_key_stop) begin
                    state_n = S_IDLE;
                end else if (i_key_play) begin
                    state_n = (state == S_PLAY) ? S_PPAUSE : S_PLAY;
                end else if (state == S_PLAY && lrck_rise) begin
                    off_n     = off + 1'b1;
                    tick_play = 1'b1;
                end
            end
            default: state_n = S_INIT;
        endcase

        if (tick_rec || tick_play) begin
            if (sub == SUB_MAX) begin
                sub_n = '0;
                if (tick_rec && o_rec_time != '1)   rec_n  = o_rec_time + 1'b1;
                if (tick_play && o_play_time != '1) play_n = o_play_time + 1'b1;
            end else begin
                sub_n = sub + 1'b1;
            end
        end

        stop_n = (state_n == S_IDLE) && (state != S_IDLE) && (state != S_INIT);
        addr_n = (ADDR_W'(slot_n) << OFF_W) | ADDR_W'(off_n);
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_INIT;
            slot_q      <= '0;
            off         <= '0;
            sub         <= '0;
            o_rec_time  <= '0;
            o_play_time <= '0;
            o_full      <= 1'b0;
            o_stop      <= 1'b0;
            o_addr      <= '0;
            lrck_d      <= 1'b0;
            for (int unsigned i = 0; i < LEN_N; i++) len[i] <= '0;
        end else begin
            state       <= state_n;
            slot_q      <= slot_n;
            off         <= off_n;
            sub         <= sub_n;
            o_rec_time  <= rec_n;
            o_play_time <= play_n;
            o_full      <= full_n;
            o_stop      <= stop_n;
            o_addr      <= addr_n;
            lrck_d      <= i_lrck;
            if (len_wr) len[slot_q] <= len_wd;
        end
    end

    assign o_state     = state;
    assign o_i2c_start = (state == S_INIT);
    assign o_rec_en    = (state == S_RECD);
    assign o_play_en   = (state == S_PLAY);
endmodule

// File: tb/tb_aud_transport_ctrl.sv
// Directed bench for aud_transport_ctrl at ADDR_W=8, SLOT_N=4, SAMPLE_RATE=16, TIME_W=6 (64-word slots).
module tb_aud_transport_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_rec, key_play, key_stop;
    logic [1:0] slot;
    logic       i2c_done, lrck;
    logic [2:0] state;
    logic       i2c_start, rec_en, play_en, stop, full;
    logic [7:0] addr;
    logic [5:0] rec_time, play_time;

    int nvec = 0;
    int nerr = 0;

    aud_transport_ctrl #(
        .ADDR_W(8), .SLOT_N(4), .SAMPLE_RATE(16), .TIME_W(6)
    ) dut (
        .i_AUD_BCLK(clk), .i_rst_n(rst_n),
        .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
        .i_slot(slot), .i_i2c_done(i2c_done), .i_lrck(lrck),
        .o_state(state), .o_i2c_start(i2c_start), .o_rec_en(rec_en), .o_play_en(play_en),
        .o_stop(stop), .o_addr(addr), .o_rec_time(rec_time), .o_play_time(play_time),
        .o_full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic r, input logic p, input logic s);
        key_rec = r; key_play = p; key_stop = s;
        tick();
        key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
    endtask

    // Rising half of one LRCK period; caller checks, then calls lrck_low.
    task automatic lrck_high();
        lrck = 1'b1;
        tick();
    endtask

    task automatic lrck_low();
        lrck = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i2c_done = 1'b0; lrck = 1'b0; slot = 2'd0;
        key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
        tick(); tick();
        nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL reset_state got %0d exp 0", state); end
        nvec++; if (i2c_start !== 1'b1) begin nerr++; $display("FAIL reset_i2c_start got %b exp 1", i2c_start); end
        nvec++; if ({rec_en, play_en, stop, full} !== 4'b0000) begin nerr++; $display("FAIL reset_flags got %b exp 0000", {rec_en, play_en, stop, full}); end
        nvec++; if (addr !== 8'd0 || rec_time !== 6'd0 || play_time !== 6'd0) begin nerr++; $display("FAIL reset_counters got addr %0d rt %0d pt %0d exp 0", addr, rec_time, play_time); end
        rst_n = 1'b1;
        key_rec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++; if (state !== 3'd0 || stop !== 1'b0) begin nerr++; $display("FAIL init_hold got state %0d stop %b exp 0/0", state, stop); end
        end
        key_rec = 1'b0;
        i2c_done = 1'b1;
        tick();
        nvec++; if (state !== 3'd1 || stop !== 1'b0 || i2c_start !== 1'b0) begin nerr++; $display("FAIL init_done got state %0d stop %b i2c %b exp 1/0/0", state, stop, i2c_start); end
    endtask

    task automatic test_record();
        slot = 2'd2;
        press(1'b1, 1'b0, 1'b0);
        nvec++; if (state !== 3'd2 || rec_en !== 1'b1 || addr !== 8'd128) begin nerr++; $display("FAIL rec_start got state %0d en %b addr %0d exp 2/1/128", state, rec_en, addr); end
        for (int k = 1; k <= 20; k++) begin
            lrck_high();
            nvec++; if (addr !== 8'(128 + k)) begin nerr++; $display("FAIL rec_addr got %0d exp %0d", addr, 128 + k); end
            lrck_low();
        end
        nvec++; if (rec_time !== 6'd1) begin nerr++; $display("FAIL rec_time got %0d exp 1", rec_time); end
        press(1'b0, 1'b0, 1'b1);
        nvec++; if (state !== 3'd1 || stop !== 1'b1 || addr !== 8'd148) begin nerr++; $display("FAIL rec_stop got state %0d stop %b addr %0d exp 1/1/148", state, stop, addr); end
        tick();
        nvec++; if (stop !== 1'b0) begin nerr++; $display("FAIL rec_stop_pulse got %b exp 0", stop); end
    endtask

    task automatic test_full();
        slot = 2'd1;
        press(1'b1, 1'b0, 1'b0);
        nvec++; if (state !== 3'd2 || addr !== 8'd64) begin nerr++; $display("FAIL full_start got state %0d addr %0d exp 2/64", state, addr); end
        for (int k = 1; k <= 70; k++) begin
            lrck_high();
            if (k < 64) begin
                nvec++; if (state !== 3'd2 || addr !== 8'(64 + k)) begin nerr++; $display("FAIL full_addr got state %0d addr %0d exp 2/%0d", state, addr, 64 + k); end
            end else if (k == 64) begin
                nvec++; if (state !== 3'd1 || stop !== 1'b1 || full !== 1'b1 || addr !== 8'd127) begin nerr++; $display("FAIL full_auto got state %0d stop %b full %b addr %0d exp 1/1/1/127", state, stop, full, addr); end
            end else begin
                nvec++; if (state !== 3'd1 || stop !== 1'b0 || addr !== 8'd127) begin nerr++; $display("FAIL full_ignore got state %0d stop %b addr %0d exp 1/0/127", state, stop, addr); end
            end
            lrck_low();
        end
        nvec++; if (full !== 1'b1 || rec_time !== 6'd4) begin nerr++; $display("FAIL full_end got full %b rt %0d exp 1/4", full, rec_time); end
    endtask

    task automatic test_play();
        slot = 2'd2;
        press(1'b0, 1'b1, 1'b0);
        nvec++; if (state !== 3'd4 || play_en !== 1'b1 || addr !== 8'd128) begin nerr++; $display("FAIL play_start got state %0d en %b addr %0d exp 4/1/128", state, play_en, addr); end
        for (int k = 1; k <= 20; k++) begin
            lrck_high();
            if (k < 20) begin
                nvec++; if (state !== 3'd4 || addr !== 8'(128 + k)) begin nerr++; $display("FAIL play_addr got state %0d addr %0d exp 4/%0d", state, addr, 128 + k); end
            end else begin
`ifdef AUD_LOOP_PLAY_EN
                nvec++; if (state !== 3'd4 || stop !== 1'b0 || addr !== 8'd128 || play_time !== 6'd0) begin nerr++; $display("FAIL play_loop got state %0d stop %b addr %0d pt %0d exp 4/0/128/0", state, stop, addr, play_time); end
`else
                nvec++; if (state !== 3'd1 || stop !== 1'b1 || addr !== 8'd147 || play_time !== 6'd1) begin nerr++; $display("FAIL play_end got state %0d stop %b addr %0d pt %0d exp 1/1/147/1", state, stop, addr, play_time); end
`endif
            end
            lrck_low();
        end
`ifdef AUD_LOOP_PLAY_EN
        press(1'b0, 1'b0, 1'b1);
        nvec++; if (state !== 3'd1 || stop !== 1'b1) begin nerr++; $display("FAIL play_loop_stop got state %0d stop %b exp 1/1", state, stop); end
`endif
    endtask

    task automatic test_empty_and_priority();
        slot = 2'd3;
        press(1'b0, 1'b1, 1'b0);
        nvec++; if (state !== 3'd1 || stop !== 1'b0) begin nerr++; $display("FAIL empty_play got state %0d stop %b exp 1/0", state, stop); end
        press(1'b1, 1'b0, 1'b0);
        nvec++; if (state !== 3'd2 || full !== 1'b0 || addr !== 8'd192) begin nerr++; $display("FAIL rec3_start got state %0d full %b addr %0d exp 2/0/192", state, full, addr); end
        press(1'b1, 1'b0, 1'b1);
        nvec++; if (state !== 3'd1 || stop !== 1'b1) begin nerr++; $display("FAIL stop_wins got state %0d stop %b exp 1/1", state, stop); end
        press(1'b0, 1'b1, 1'b0);
        nvec++; if (state !== 3'd1) begin nerr++; $display("FAIL empty_again got state %0d exp 1", state); end
    endtask

    task automatic test_pause();
        slot = 2'd2;
        press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin lrck_high(); lrck_low(); end
        nvec++; if (state !== 3'd4 || addr !== 8'd133) begin nerr++; $display("FAIL pause_pre got state %0d addr %0d exp 4/133", state, addr); end
        press(1'b0, 1'b1, 1'b0);
        nvec++; if (state !== 3'd5 || play_en !== 1'b0) begin nerr++; $display("FAIL pause_enter got state %0d en %b exp 5/0", state, play_en); end
        for (int k = 0; k < 10; k++) begin
            lrck_high();
            nvec++; if (state !== 3'd5 || addr !== 8'd133) begin nerr++; $display("FAIL pause_hold got state %0d addr %0d exp 5/133", state, addr); end
            lrck_low();
        end
        press(1'b0, 1'b1, 1'b0);
        nvec++; if (state !== 3'd4 || addr !== 8'd133) begin nerr++; $display("FAIL pause_resume got state %0d addr %0d exp 4/133", state, addr); end
        lrck_high(); lrck_low();
        nvec++; if (addr !== 8'd134) begin nerr++; $display("FAIL pause_next got addr %0d exp 134", addr); end
        press(1'b0, 1'b0, 1'b1);
        nvec++; if (state !== 3'd1 || stop !== 1'b1) begin nerr++; $display("FAIL pause_stop got state %0d stop %b exp 1/1", state, stop); end
    endtask

    task automatic test_back_to_back();
        slot = 2'd0;
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin lrck_high(); lrck_low(); end
        press(1'b1, 1'b0, 1'b0);
        nvec++; if (state !== 3'd3 || rec_en !== 1'b0 || addr !== 8'd3) begin nerr++; $display("FAIL rpause got state %0d en %b addr %0d exp 3/0/3", state, rec_en, addr); end
        for (int k = 0; k < 2; k++) begin lrck_high(); lrck_low(); end
        nvec++; if (addr !== 8'd3) begin nerr++; $display("FAIL rpause_hold got addr %0d exp 3", addr); end
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin lrck_high(); lrck_low(); end
        nvec++; if (state !== 3'd2 || addr !== 8'd5) begin nerr++; $display("FAIL rresume got state %0d addr %0d exp 2/5", state, addr); end
        press(1'b0, 1'b1, 1'b0);
        nvec++; if (state !== 3'd4 || addr !== 8'd0 || stop !== 1'b0) begin nerr++; $display("FAIL rec_to_play got state %0d addr %0d stop %b exp 4/0/0", state, addr, stop); end
        lrck_high(); lrck_low();
        press(1'b1, 1'b0, 1'b0);
        nvec++; if (state !== 3'd4 || addr !== 8'd1) begin nerr++; $display("FAIL rec_ignored got state %0d addr %0d exp 4/1", state, addr); end
        for (int k = 2; k <= 5; k++) begin
            lrck_high();
            if (k < 5) begin
                nvec++; if (addr !== 8'(k)) begin nerr++; $display("FAIL b2b_addr got %0d exp %0d", addr, k); end
            end else begin
`ifdef AUD_LOOP_PLAY_EN
                nvec++; if (state !== 3'd4 || addr !== 8'd0) begin nerr++; $display("FAIL b2b_loop got state %0d addr %0d exp 4/0", state, addr); end
`else
                nvec++; if (state !== 3'd1 || addr !== 8'd4 || stop !== 1'b1) begin nerr++; $display("FAIL b2b_end got state %0d addr %0d stop %b exp 1/4/1", state, addr, stop); end
`endif
            end
            lrck_low();
        end
    endtask

    initial begin
        test_reset();
        test_record();
        test_full();
        test_play();
        test_empty_and_priority();
        test_pause();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
